// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Keeps the next fetch address (pc), issues one read
// at a time to instruction memory, and presents the fetched word to decode
// through a one-entry output register backed by a one-entry skid buffer, so a
// read that completes while decode is stalled is never lost. A redirect from
// the branch stage flushes everything held and restarts fetch at the target;
// a read already on the bus when the redirect arrives is allowed to finish
// and its data is thrown away.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   stall        : decode cannot accept the held instruction this cycle
//   redirect     : taken branch / jump, restart fetch at redirect_pc
//   redirect_pc  : redirect target address
//   imem_req     : instruction memory read request
//   imem_addr    : address of the request (held until the read completes)
//   imem_ready   : read completes in a cycle with imem_req & imem_ready
//   imem_rdata   : read data, valid on completion
//   instr_valid  : instr / opcode / pc_out / pc_plus4 are valid for decode
//   instr        : held instruction word
//   opcode       : instr[31:27]
//   pc_out       : address of the held instruction
//   pc_plus4     : pc_out + 4 (link value), wraps modulo 2^32
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [4:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_addr;

    // Output register presented to decode.
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;

    // Skid buffer: catches a word that completes while decode is stalled.
    logic        r_skid_valid;
    logic [31:0] r_skid_data;
    logic [31:0] r_skid_addr;

    logic        w_done;
    logic        w_accept;
    logic        w_can_load;
    logic [31:0] w_pc_inc;

    assign w_done     = r_req & imem_ready;
    assign w_accept   = r_valid & ~stall;
    assign w_can_load = ~r_valid | w_accept;
    assign w_pc_inc   = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_pc_out     <= 32'd0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 32'd0;
            r_skid_addr  <= 32'd0;
        end else begin
            // Decode consumed the held word; a load below may refill it.
            if (w_accept) begin
                r_valid <= 1'b0;
            end

            // Flush wins over everything else that touches the held state.
            if (redirect) begin
                r_valid      <= 1'b0;
                r_skid_valid <= 1'b0;
                r_pc         <= redirect_pc;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b0;
                    r_addr  <= redirect ? redirect_pc : r_pc;
                end

                // S_REQ spends one cycle with the request low (address being
                // set up) and then raises it until the read completes, which
                // gives at best one fetch every two cycles.
                S_REQ: begin
                    if (redirect) begin
                        if (r_req && !imem_ready) begin
                            // Read in flight: finish it on the old address.
                            r_state <= S_DRAIN;
                        end else begin
                            // Nothing outstanding, or the completing data is
                            // simply dropped; refetch from the target.
                            r_req  <= 1'b0;
                            r_addr <= redirect_pc;
                        end
                    end else if (w_done) begin
                        r_req  <= 1'b0;
                        r_pc   <= w_pc_inc;
                        r_addr <= w_pc_inc;
                        if (w_can_load) begin
                            r_valid  <= 1'b1;
                            r_instr  <= imem_rdata;
                            r_pc_out <= r_addr;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= imem_rdata;
                            r_skid_addr  <= r_addr;
                            r_state      <= S_FULL;
                        end
                    end else begin
                        r_req <= 1'b1;
                    end
                end

                S_FULL: begin
                    if (redirect) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b0;
                        r_addr  <= redirect_pc;
                    end else if (w_accept) begin
                        r_valid      <= 1'b1;
                        r_instr      <= r_skid_data;
                        r_pc_out     <= r_skid_addr;
                        r_skid_valid <= 1'b0;
                        r_state      <= S_REQ;
                        r_req        <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (w_done) begin
                        // Stale data discarded; resume from the newest pc.
                        r_state <= S_REQ;
                        r_req   <= 1'b0;
                        r_addr  <= redirect ? redirect_pc : r_pc;
                    end else begin
                        r_req <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:27];
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_out + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. Instruction memory returns
// addr ^ 32'hDEAD_0000 combinationally, so expected words follow from the
// address. Inputs change #1 after a rising edge, outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
    );

    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b1;

        // Reset state
        step();
        step();
        check_eq("rst_req",   {31'd0, imem_req},    32'd0);
        check_eq("rst_addr",  imem_addr,            32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr,                32'd0);
        check_eq("rst_pcout", pc_out,               32'd0);
        rst = 1'b0;

        // Streaming fetch, ready tied high, no stall
        step(); // edge1: S_REQ, request still low
        check_eq("e1_req",  {31'd0, imem_req}, 32'd0);
        check_eq("e1_addr", imem_addr,         32'd0);
        step(); // edge2
        check_eq("e2_req",  {31'd0, imem_req}, 32'd1);
        check_eq("e2_addr", imem_addr,         32'd0);
        step(); // edge3: first word delivered
        check_eq("e3_valid",  {31'd0, instr_valid}, 32'd1);
        check_eq("e3_pcout",  pc_out,               32'd0);
        check_eq("e3_plus4",  pc_plus4,             32'd4);
        check_eq("e3_instr",  instr,                32'hDEAD_0000);
        check_eq("e3_opcode", {27'd0, opcode},      32'h1B);
        check_eq("e3_req",    {31'd0, imem_req},    32'd0);
        step(); // edge4
        check_eq("e4_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("e4_addr",  imem_addr,            32'd4);
        check_eq("e4_req",   {31'd0, imem_req},    32'd1);
        step(); // edge5
        check_eq("e5_pcout", pc_out, 32'd4);
        step(); // edge6
        check_eq("e6_addr", imem_addr,         32'd8);
        check_eq("e6_req",  {31'd0, imem_req}, 32'd1);

        // Stall while two reads complete
        stall = 1'b1;
        step(); // edge7: word 8 into output register
        check_eq("e7_pcout", pc_out, 32'd8);
        step(); // edge8
        check_eq("e8_addr", imem_addr, 32'd12);
        step(); // edge9: word 12 into skid buffer
        check_eq("e9_req",   {31'd0, imem_req}, 32'd0);
        check_eq("e9_pcout", pc_out,            32'd8);
        step(); // edge10: hold
        check_eq("e10_req",   {31'd0, imem_req}, 32'd0);
        check_eq("e10_instr", instr,             32'hDEAD_0008);
        stall = 1'b0;
        step(); // edge11: skid word delivered
        check_eq("e11_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("e11_pcout", pc_out,               32'd12);
        check_eq("e11_instr", instr,                32'hDEAD_000C);
        step(); // edge12
        check_eq("e12_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("e12_addr",  imem_addr,            32'd16);
        check_eq("e12_req",   {31'd0, imem_req},    32'd1);

        // Redirect while a read waits
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step(); // edge13: drain
        redirect = 1'b0;
        check_eq("e13_addr", imem_addr,         32'd16);
        check_eq("e13_req",  {31'd0, imem_req}, 32'd1);
        step();
        step(); // edge15
        check_eq("e15_addr", imem_addr, 32'd16);
        imem_ready = 1'b1;
        step(); // edge16: stale data discarded
        check_eq("e16_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("e16_addr",  imem_addr,            32'h100);
        step(); // edge17
        check_eq("e17_req", {31'd0, imem_req}, 32'd1);
        step(); // edge18
        check_eq("e18_pcout", pc_out, 32'h100);
        check_eq("e18_instr", instr,  32'hDEAD_0100);

        // Redirect with skid buffer full and stall, then with completion
        stall = 1'b1;
        step(); // edge19
        step(); // edge20: 0x104 into skid
        check_eq("e20_req",   {31'd0, imem_req}, 32'd0);
        check_eq("e20_pcout", pc_out,            32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step(); // edge21
        redirect = 1'b0;
        check_eq("e21_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("e21_addr",  imem_addr,            32'h200);
        step(); // edge22
        check_eq("e22_req", {31'd0, imem_req}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step(); // edge23: completing data at 0x200 dropped
        check_eq("e23_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("e23_addr",  imem_addr,            32'h300);
        stall = 1'b0;

        // Wrap at top of address space
        redirect_pc = 32'hFFFF_FFFC;
        step(); // edge24
        redirect = 1'b0;
        check_eq("e24_addr", imem_addr, 32'hFFFF_FFFC);
        step(); // edge25
        step(); // edge26
        check_eq("e26_pcout", pc_out,   32'hFFFF_FFFC);
        check_eq("e26_plus4", pc_plus4, 32'd0);
        check_eq("e26_addr",  imem_addr, 32'd0);

        // Reset in S_DRAIN
        step(); // edge27
        step(); // edge28
        check_eq("e28_pcout", pc_out, 32'd0);
        step(); // edge29
        check_eq("e29_addr", imem_addr, 32'd4);
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        step(); // edge30: S_DRAIN on address 4
        redirect = 1'b0;
        check_eq("e30_addr", imem_addr,         32'd4);
        check_eq("e30_req",  {31'd0, imem_req}, 32'd1);
        #2;
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        check_eq("arst_req",   {31'd0, imem_req},    32'd0);
        check_eq("arst_addr",  imem_addr,            32'd0);
        check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("arst_pcout", pc_out,               32'd0);
        step();
        check_eq("arst_hold_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        step();
        step();
        check_eq("rs_req",  {31'd0, imem_req}, 32'd1);
        check_eq("rs_addr", imem_addr,         32'd0);
        step();
        check_eq("rs_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("rs_pcout", pc_out,               32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
